trace_checker: RTL and testbench
================================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 36, meaning trace word width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port clear  input  1  synchronous restart: empty FIFO, clear flags and counters.
REQ-006 SHALL have port trace_valid_0  input  1  core 0 retired-instruction trace strobe.
REQ-007 SHALL have port trace_data_0  input  WIDTH  core 0 trace word.
REQ-008 SHALL have port trace_valid_1  input  1  core 1 trace strobe.
REQ-009 SHALL have port trace_data_1  input  WIDTH  core 1 trace word.
REQ-010 SHALL have port mismatch  output  1  sticky: compared words differed.
REQ-011 SHALL have port overflow  output  1  sticky: push into full FIFO.
REQ-012 SHALL have port fail_data_0  output  WIDTH  core 0 word of the failing comparison.
REQ-013 SHALL have port fail_data_1  output  WIDTH  core 1 word of the failing comparison.
REQ-014 SHALL have port match_count  output  32  successful comparisons, saturating.
REQ-015 SHALL have port pending  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port leader  output  2  state: 0 EMPTY, 1 LEAD0, 2 LEAD1, 3 FAIL.

Function
REQ-017 SHALL hold words from the leading core only; FIFO contents always belong to one side, given by leader.
REQ-018 EMPTY, one strobe only: push that word, go LEAD0 or LEAD1; pending becomes 1.
REQ-019 EMPTY, both strobes: compare trace_data_0 with trace_data_1 directly; no push; stay EMPTY.
REQ-020 LEADx, strobe from leader only: push; if pending==DEPTH then no push, set overflow, go FAIL.
REQ-021 LEADx, strobe from lagging side only: compare FIFO head with lagging word, pop; go EMPTY when pending reaches 0.
REQ-022 LEADx, both strobes: compare head with lagging word, pop head, push leader word same cycle; pending unchanged; never overflow, even when full.
REQ-023 Compare order: fail_data_0 always takes core 0 word, fail_data_1 the core 1 word, whichever side came from the FIFO.
REQ-024 Equal compare: match_count +1, saturating at 32'hFFFFFFFF.
REQ-025 Unequal compare: set mismatch, capture both words into fail_data_*, go FAIL; match_count unchanged.
REQ-026 FAIL: ignore all strobes; all outputs hold until clear or reset.
REQ-027 At most one comparison per cycle; comparison is exact on all WIDTH bits.
REQ-028 All outputs registered; flags and counters update the cycle after the triggering strobes.
REQ-029 clear takes priority over strobes in the same cycle; strobes in that cycle are dropped.
REQ-030 FIFO SHALL use wrapping read/write pointers of $clog2(DEPTH) bits plus a separate occupancy count.

Reset
REQ-031 While reset is high: leader=0, pending=0, mismatch=0, overflow=0, match_count=0, fail_data_0=0, fail_data_1=0; FIFO pointers 0.
REQ-032 Reset assertion mid-operation SHALL discard FIFO contents immediately; first edge after deassertion behaves as EMPTY.
REQ-033 clear SHALL produce the same register values as reset, one cycle later, synchronously.

Verification
REQ-034 Both strobes every cycle, identical data 0..99 -> match_count=100, pending=0, leader=0, no flags.
REQ-035 Core 0 sends A,B,C; core 1 later sends A,B,C -> pending 1,2,3 then 2,1,0; leader 1 then 0; match_count=3.
REQ-036 Core 1 leads by 2, then core 0 sends word differing in bit 35 -> mismatch=1, leader=3, fail_data_0/1 hold the two words, later strobes ignored.
REQ-037 DEPTH=16: core 0 sends 17 words, core 1 none -> 17th sets overflow, pending stays 16, leader=3.
REQ-038 FIFO full with LEAD0, both strobes with matching head -> pending stays 16, no overflow, match_count +1.
REQ-039 clear asserted in the same cycle as both strobes while in FAIL -> next cycle all outputs zero, strobes dropped.

Source files
------------

// File: rtl/trace_checker_if.sv
// Trace strobe/data bundle from the two lockstep cores into the trace checker.
interface trace_checker_if #(
    parameter int WIDTH = 36
);
    logic             trace_valid_0;
    logic [WIDTH-1:0] trace_data_0;
    logic             trace_valid_1;
    logic [WIDTH-1:0] trace_data_1;

    modport master (
        output trace_valid_0, trace_data_0, trace_valid_1, trace_data_1
    );

    modport slave (
        input  trace_valid_0, trace_data_0, trace_valid_1, trace_data_1
    );
endinterface

// File: rtl/trace_checker.sv
// Dual-core retired-instruction trace comparator: buffers the leading core's
// words and compares them in order against the lagging core's words.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | FIFO empty, cores in step
// S_LEAD0 | FIFO holds core 0 words awaiting core 1
// S_LEAD1 | FIFO holds core 1 words awaiting core 0
// S_FAIL  | mismatch or overflow seen; frozen until clear/reset
module trace_checker #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    trace_checker_if.slave         trc,
    output logic                   mismatch,
    output logic                   overflow,
    output logic [WIDTH-1:0]       fail_data_0,
    output logic [WIDTH-1:0]       fail_data_1,
    output logic [31:0]            match_count,
    output logic [$clog2(DEPTH):0] pending,
    output logic [1:0]             leader
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LEAD0 = 2'd1,
        S_LEAD1 = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [WIDTH-1:0]  head;

    logic              push;
    logic              pop;
    logic              cmp;
    logic              ovf;
    logic [WIDTH-1:0]  push_word;
    logic [WIDTH-1:0]  cmp_0;
    logic [WIDTH-1:0]  cmp_1;

    assign head   = mem[rd_ptr];
    assign leader = state;

    // Compare operands are always ordered core 0 / core 1, regardless of
    // which side was sitting in the FIFO.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        cmp       = 1'b0;
        ovf       = 1'b0;
        push_word = trc.trace_data_0;
        cmp_0     = trc.trace_data_0;
        cmp_1     = trc.trace_data_1;
        if (!clear) begin
            unique case (state)
                S_EMPTY: begin
                    if (trc.trace_valid_0 && trc.trace_valid_1) begin
                        cmp = 1'b1;
                    end else if (trc.trace_valid_0) begin
                        push = 1'b1;
                    end else if (trc.trace_valid_1) begin
                        push      = 1'b1;
                        push_word = trc.trace_data_1;
                    end
                end
                S_LEAD0: begin
                    if (trc.trace_valid_1) begin
                        cmp   = 1'b1;
                        pop   = 1'b1;
                        cmp_0 = head;
                        push  = trc.trace_valid_0;
                    end else if (trc.trace_valid_0) begin
                        ovf  = (pending == CNT_FULL);
                        push = (pending != CNT_FULL);
                    end
                end
                S_LEAD1: begin
                    push_word = trc.trace_data_1;
                    if (trc.trace_valid_0) begin
                        cmp   = 1'b1;
                        pop   = 1'b1;
                        cmp_1 = head;
                        push  = trc.trace_valid_1;
                    end else if (trc.trace_valid_1) begin
                        ovf  = (pending == CNT_FULL);
                        push = (pending != CNT_FULL);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_EMPTY;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pending     <= '0;
            mismatch    <= 1'b0;
            overflow    <= 1'b0;
            fail_data_0 <= '0;
            fail_data_1 <= '0;
            match_count <= '0;
        end else if (clear) begin
            state       <= S_EMPTY;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pending     <= '0;
            mismatch    <= 1'b0;
            overflow    <= 1'b0;
            fail_data_0 <= '0;
            fail_data_1 <= '0;
            match_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      pending <= pending + CNT_ONE;
            else if (pop && !push) pending <= pending - CNT_ONE;

            unique case (state)
                S_EMPTY: if (push) state <= trc.trace_valid_0 ? S_LEAD0 : S_LEAD1;
                S_LEAD0, S_LEAD1: if (pop && !push && pending == CNT_ONE) state <= S_EMPTY;
                default: ;
            endcase

            if (ovf) begin
                overflow <= 1'b1;
                state    <= S_FAIL;
            end

            // A failing compare overrides any EMPTY/LEAD transition above.
            if (cmp) begin
                if (cmp_0 == cmp_1) begin
                    if (match_count != 32'hFFFF_FFFF) match_count <= match_count + 32'd1;
                end else begin
                    mismatch    <= 1'b1;
                    fail_data_0 <= cmp_0;
                    fail_data_1 <= cmp_1;
                    state       <= S_FAIL;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_trace_checker;
    localparam int DEPTH = 16;
    localparam int WIDTH = 36;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    logic             mismatch, overflow;
    logic [WIDTH-1:0] fail_data_0, fail_data_1;
    logic [31:0]      match_count;
    logic [$clog2(DEPTH):0] pending;
    logic [1:0]       leader;

    trace_checker_if #(.WIDTH(WIDTH)) trc ();

    trace_checker #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .trc         (trc),
        .mismatch    (mismatch),
        .overflow    (overflow),
        .fail_data_0 (fail_data_0),
        .fail_data_1 (fail_data_1),
        .match_count (match_count),
        .pending     (pending),
        .leader      (leader)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: lead 0 empty, 1 core 0 ahead, 2 core 1 ahead, 3 failed.
    logic [WIDTH-1:0] q [$];
    int               m_lead;
    bit               m_mm, m_ovf;
    logic [WIDTH-1:0] m_f0, m_f1;
    logic [31:0]      m_mc;

    function automatic void model_reset();
        q.delete();
        m_lead = 0;
        m_mm   = 1'b0;
        m_ovf  = 1'b0;
        m_f0   = '0;
        m_f1   = '0;
        m_mc   = '0;
    endfunction

    function automatic void model_cmp(logic [WIDTH-1:0] w0, logic [WIDTH-1:0] w1);
        if (w0 == w1) begin
            if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        end else begin
            m_mm   = 1'b1;
            m_f0   = w0;
            m_f1   = w1;
            m_lead = 3;
        end
    endfunction

    function automatic void model_step(bit clr, bit v0, logic [WIDTH-1:0] d0,
                                       bit v1, logic [WIDTH-1:0] d1);
        bit               lead_v, lag_v;
        logic [WIDTH-1:0] lead_w, h;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_lead == 3) return;
        if (m_lead == 0) begin
            if (v0 && v1)  model_cmp(d0, d1);
            else if (v0) begin q.push_back(d0); m_lead = 1; end
            else if (v1) begin q.push_back(d1); m_lead = 2; end
            return;
        end
        lead_v = (m_lead == 1) ? v0 : v1;
        lag_v  = (m_lead == 1) ? v1 : v0;
        lead_w = (m_lead == 1) ? d0 : d1;
        if (lag_v) begin
            h = q.pop_front();
            if (m_lead == 1) model_cmp(h, d1);
            else             model_cmp(d0, h);
            if (lead_v) q.push_back(lead_w);
            if (m_lead != 3 && q.size() == 0) m_lead = 0;
        end else if (lead_v) begin
            if (q.size() == DEPTH) begin
                m_ovf  = 1'b1;
                m_lead = 3;
            end else begin
                q.push_back(lead_w);
            end
        end
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".leader"},      64'(leader),      64'(m_lead));
        chk({tag, ".pending"},     64'(pending),     64'(q.size()));
        chk({tag, ".mismatch"},    64'(mismatch),    64'(m_mm));
        chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
        chk({tag, ".match_count"}, 64'(match_count), 64'(m_mc));
        chk({tag, ".fail_data_0"}, 64'(fail_data_0), 64'(m_f0));
        chk({tag, ".fail_data_1"}, 64'(fail_data_1), 64'(m_f1));
    endtask

    task automatic step(string tag, bit clr, bit v0, logic [WIDTH-1:0] d0,
                        bit v1, logic [WIDTH-1:0] d1);
        clear             = clr;
        trc.trace_valid_0 = v0;
        trc.trace_data_0  = d0;
        trc.trace_valid_1 = v1;
        trc.trace_data_1  = d1;
        @(posedge clk);
        #1;
        model_step(clr, v0, d0, v1, d1);
        check_all(tag);
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    initial begin
        logic [WIDTH-1:0] w [DEPTH+1];
        logic [WIDTH-1:0] x, y, d0, d1;
        bit v0, v1, clr;

        reset = 1'b1;
        clear = 1'b0;
        trc.trace_valid_0 = 1'b0;
        trc.trace_valid_1 = 1'b0;
        trc.trace_data_0  = '0;
        trc.trace_data_1  = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Lockstep, identical data 0..99
        for (int i = 0; i < 100; i++)
            step("lockstep", 1'b0, 1'b1, WIDTH'(i), 1'b1, WIDTH'(i));
        chk("lockstep.final_mc", 64'(match_count), 64'd100);

        // Core 0 leads by three words, core 1 catches up
        step("pre035_clr", 1'b1, 1'b0, '0, 1'b0, '0);
        x = rnd_word();
        y = rnd_word();
        d0 = rnd_word();
        step("lead0_a", 1'b0, 1'b1, x,  1'b0, '0);
        step("lead0_b", 1'b0, 1'b1, y,  1'b0, '0);
        step("lead0_c", 1'b0, 1'b1, d0, 1'b0, '0);
        chk("lead0.pending3", 64'(pending), 64'd3);
        step("lag1_a", 1'b0, 1'b0, '0, 1'b1, x);
        step("lag1_b", 1'b0, 1'b0, '0, 1'b1, y);
        step("lag1_c", 1'b0, 1'b0, '0, 1'b1, d0);
        chk("lag1.mc3", 64'(match_count), 64'd3);
        chk("lag1.leader0", 64'(leader), 64'd0);

        // Core 1 leads by two, core 0 differs in bit 35
        step("pre036_clr", 1'b1, 1'b0, '0, 1'b0, '0);
        step("lead1_a", 1'b0, 1'b0, '0, 1'b1, x);
        step("lead1_b", 1'b0, 1'b0, '0, 1'b1, y);
        step("bit35",   1'b0, 1'b1, x ^ (WIDTH'(1) << 35), 1'b0, '0);
        chk("bit35.leader3", 64'(leader), 64'd3);
        for (int i = 0; i < 4; i++)
            step("fail_hold", 1'b0, 1'b1, rnd_word(), 1'b1, rnd_word());

        // Clear wins over strobes while in FAIL
        step("clr_in_fail", 1'b1, 1'b1, x, 1'b1, y);
        chk("clr_in_fail.mm0", 64'(mismatch), 64'd0);

        // Seventeen words into a sixteen-deep FIFO
        for (int i = 0; i <= DEPTH; i++) begin
            w[i] = rnd_word();
            step("fill17", 1'b0, 1'b1, w[i], 1'b0, '0);
        end
        chk("fill17.ovf", 64'(overflow), 64'd1);
        chk("fill17.pending16", 64'(pending), 64'd16);

        // Full FIFO, both strobes with matching head
        step("pre038_clr", 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++)
            step("fill16", 1'b0, 1'b1, w[i], 1'b0, '0);
        step("full_both", 1'b0, 1'b1, w[DEPTH], 1'b1, w[0]);
        chk("full_both.ovf0", 64'(overflow), 64'd0);
        chk("full_both.mc1",  64'(match_count), 64'd1);
        for (int i = 1; i <= DEPTH; i++)
            step("drain", 1'b0, 1'b0, '0, 1'b1, w[i]);

        // Random traffic; the lagging core usually replays the correct word
        for (int i = 0; i < 3000; i++) begin
            v0  = ($urandom_range(99) < 55);
            v1  = ($urandom_range(99) < 55);
            d0  = rnd_word();
            d1  = rnd_word();
            clr = (m_lead == 3) ? ($urandom_range(3) == 0) : ($urandom_range(299) == 0);
            if ($urandom_range(99) < 97) begin
                if (m_lead == 0)      d1 = d0;
                else if (m_lead == 1) d1 = q[0];
                else if (m_lead == 2) d0 = q[0];
            end
            step("random", clr, v0, d0, v1, d1);
        end

        // Asynchronous reset mid-operation discards the FIFO immediately
        step("pre_rst_clr", 1'b1, 1'b0, '0, 1'b0, '0);
        step("pre_rst_a", 1'b0, 1'b1, x, 1'b0, '0);
        step("pre_rst_b", 1'b0, 1'b1, y, 1'b0, '0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        reset = 1'b0;
        step("post_rst", 1'b0, 1'b0, '0, 1'b1, y);
        chk("post_rst.leader2", 64'(leader), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
